two_phase_clk_gen: RTL
======================

// Module: two_phase_clk_gen
// PURPOSE
//   Drives the complementary enable pairs (CLK/nCLK) of the latch-based datapath
//   from one fast system clock. Produces two non-overlapping phases, PHI1 and PHI2,
//   with registered complements. Programmable high time and dead time.
//   Run, stop and single-step control serve bring-up.
//   Sits at the top level, feeding every D_LATCH bank and TINV bus-driver enable.
// PARAMETERS
//   W         4   width of HI_CYC / GAP_CYC and of the internal phase counter
// PORTS
//   CLK       in   1  system clock, all state on rising edge
//   RST       in   1  asynchronous, active-high reset
//   RUN       in   1  level; 1 = generate machine cycles continuously
//   STEP      in   1  one-CLK pulse; request exactly one machine cycle (IDLE only)
//   HI_CYC    in   W  CLK cycles each phase is high (0 treated as 1)
//   GAP_CYC   in   W  CLK cycles of dead time after each phase (0 treated as 1)
//   PHI1      out  1  phase-1 enable
//   nPHI1     out  1  complement of PHI1
//   PHI2      out  1  phase-2 enable
//   nPHI2     out  1  complement of PHI2
//   BUSY      out  1  1 while a machine cycle is in progress
//   STEP_ACK  out  1  one-CLK pulse when a stepped machine cycle completes
// BEHAVIOUR
// - Reset (async, any state): IDLE; PHI1=PHI2=0, nPHI1=nPHI2=1; BUSY=0, STEP_ACK=0;
//   counter=0; step flag cleared. Outputs stay at these values until RST is released.
// - All outputs come straight from flops; no combinational paths to outputs.
//   nPHIx is its own flop loaded with ~next(PHIx).
//   nPHIx == ~PHIx holds on every cycle, so a latch never sees EN=nEN=1.
// - FSM: IDLE -> P1 -> GAP1 -> P2 -> GAP2 -> (P1 | IDLE).
//   P1: PHI1=1. P2: PHI2=1. IDLE/GAP1/GAP2: both phases 0.
// - Timing values:
//   H = (HI_CYC==0) ? 1 : HI_CYC, and G = (GAP_CYC==0) ? 1 : GAP_CYC.
//   Both are sampled on every entry to P1 and held for the whole machine cycle.
//   P1 and P2 each last H CLKs; GAP1 and GAP2 each last G CLKs.
//   Machine cycle = 2H+2G CLKs. PHI1 and PHI2 are never 1 together.
// - Start: in IDLE, RUN=1 or STEP=1 sampled at an edge moves the FSM to P1 at that
//   edge. PHI1=1 and BUSY=1 appear on the first clock after the request (latency 1).
//   RUN and STEP together in IDLE: RUN wins and the step flag is not set.
// - Step: STEP accepted in IDLE sets the step flag. STEP in any other state is ignored.
// - End of GAP2 (last CLK):
//   - If the step flag is set: STEP_ACK=1 for exactly the next CLK, and the flag clears.
//   - Then, if RUN=1: go to P1 (back-to-back, no idle gap). Otherwise go to IDLE, BUSY=0.
// - Deasserting RUN mid-cycle never truncates a phase or gap. The current machine
//   cycle always completes through GAP2.
// - HI_CYC/GAP_CYC changes mid-cycle take effect only at the next P1 entry.
// - Reset mid-operation aborts immediately, with phases low and complements high.
//   No STEP_ACK is issued for the aborted cycle.
// TESTING
// 1. RUN=1, H=3, G=1 -> PHI1 1 for 3 clk, 0 for 1, PHI2 1 for 3 clk, 0 for 1.
//    Period 8, repeating. PHI1 rises 1 clk after RUN is sampled.
// 2. IDLE, STEP pulse, RUN=0, H=2, G=2 -> one 8-clk cycle, then STEP_ACK=1 for 1 clk.
//    BUSY falls with it; no further PHI1 edge.
// 3. HI_CYC=0, GAP_CYC=0, RUN=1 -> treated as H=G=1. Period 4: PHI1, gap, PHI2, gap.
// 4. RUN=1, H=4, G=2; drop RUN in the 2nd clk of P2 -> P2 finishes (4 clk).
//    GAP2 finishes (2 clk), then IDLE with BUSY=0. Change HI_CYC to 1 during P1:
//    the current cycle keeps H=4, and the next cycle uses H=1.
// 5. RUN=1, H=3, G=1; assert RST in the 2nd clk of P1 -> PHI1=0, nPHI1=1, BUSY=0
//    immediately, without waiting for an edge. After release with RUN=1, restart at P1.
// 6. Random RUN/STEP/HI_CYC/GAP_CYC for 10k clk -> assertions hold every cycle:
//    nPHIx==~PHIx; !(PHI1&PHI2); each phase high exactly H clk; each STEP_ACK maps
//    to one accepted STEP.

Source files
------------

// File: rtl/two_phase_clk_gen.sv
// Two-phase non-overlapping clock generator with run/step control.
// Ports: CLK, RST (async high), RUN, STEP, HI_CYC, GAP_CYC -> PHI1/nPHI1, PHI2/nPHI2, BUSY, STEP_ACK.
module two_phase_clk_gen #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         RUN,
  input  logic         STEP,
  input  logic [W-1:0] HI_CYC,
  input  logic [W-1:0] GAP_CYC,
  output logic         PHI1,
  output logic         nPHI1,
  output logic         PHI2,
  output logic         nPHI2,
  output logic         BUSY,
  output logic         STEP_ACK
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    GAP1,
    P2,
    GAP2
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [W-1:0] h, h_n;
  logic [W-1:0] g, g_n;
  logic         flag, flag_n;
  logic         ack_n;
  logic [W-1:0] hi_eff, gap_eff, dur;
  logic         last;

  assign hi_eff  = (HI_CYC == '0) ? ONE : HI_CYC;
  assign gap_eff = (GAP_CYC == '0) ? ONE : GAP_CYC;

  // Held durations are always >= 1, so dur-1 never wraps.
  assign dur  = (state == P1 || state == P2) ? h : g;
  assign last = (cnt == dur - ONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + ONE;
    h_n     = h;
    g_n     = g;
    flag_n  = flag;
    ack_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (RUN || STEP) begin
          state_n = P1;
          h_n     = hi_eff;
          g_n     = gap_eff;
          flag_n  = STEP && !RUN;
        end
      end
      P1: begin
        if (last) begin
          state_n = GAP1;
          cnt_n   = '0;
        end
      end
      GAP1: begin
        if (last) begin
          state_n = P2;
          cnt_n   = '0;
        end
      end
      P2: begin
        if (last) begin
          state_n = GAP2;
          cnt_n   = '0;
        end
      end
      GAP2: begin
        if (last) begin
          cnt_n  = '0;
          ack_n  = flag;
          flag_n = 1'b0;
          if (RUN) begin
            state_n = P1;
            h_n     = hi_eff;
            g_n     = gap_eff;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      h        <= ONE;
      g        <= ONE;
      flag     <= 1'b0;
      PHI1     <= 1'b0;
      nPHI1    <= 1'b1;
      PHI2     <= 1'b0;
      nPHI2    <= 1'b1;
      BUSY     <= 1'b0;
      STEP_ACK <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      h        <= h_n;
      g        <= g_n;
      flag     <= flag_n;
      // Outputs decoded from the next state so they are pure flops.
      PHI1     <= (state_n == P1);
      nPHI1    <= !(state_n == P1);
      PHI2     <= (state_n == P2);
      nPHI2    <= !(state_n == P2);
      BUSY     <= (state_n != IDLE);
      STEP_ACK <= ack_n;
    end
  end

endmodule
